vga_scan_gen: RTL and testbench

Raster timing generator that drives the pixel-position side of the board display. It sweeps a col/row counter pair across a configurable VGA frame, 640x480@60 by default. It produces horizontal and vertical sync, blanking flags and a frame-start strobe, all registered and aligned to the same pixel position. Its row/col/vnotactive outputs connect directly to the display module's inputs of the same names; hsync/vsync go to the connector.

---
 rtl/vga_pkg.sv | 26 ++
 rtl/vga_axis_counter.sv | 87 ++++++++
 rtl/vga_scan_gen.sv | 128 ++++++++++++
 tb/tb_vga_scan_gen.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA raster generator: axis FSM states and the
// default 640x480@60 timing constants.
package vga_pkg;

   typedef enum logic [1:0] {
      AX_ACTIVE = 2'd0,
      AX_FRONT  = 2'd1,
      AX_SYNC   = 2'd2,
      AX_BACK   = 2'd3
   } vga_axis_e;

   localparam int unsigned VGA_H_ACTIVE = 640;
   localparam int unsigned VGA_H_FP     = 16;
   localparam int unsigned VGA_H_SYNC   = 96;
   localparam int unsigned VGA_H_BP     = 48;
   localparam int unsigned VGA_V_ACTIVE = 480;
   localparam int unsigned VGA_V_FP     = 10;
   localparam int unsigned VGA_V_SYNC   = 2;
   localparam int unsigned VGA_V_BP     = 33;

   // Counter width able to hold 0 .. total-1, never narrower than one bit.
   function automatic int unsigned vga_cnt_w(input int unsigned total);
      return (total > 1) ? $clog2(total) : 1;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK FSM driven by
// an in-state length counter. Everything steps only when adv is high.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int unsigned ACTIVE = VGA_H_ACTIVE,
   parameter int unsigned FP     = VGA_H_FP,
   parameter int unsigned SYNC   = VGA_H_SYNC,
   parameter int unsigned BP     = VGA_H_BP,
   localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP,
   localparam int unsigned W     = vga_cnt_w(TOTAL)
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         adv,
   output logic [W-1:0] pos,
   output logic [1:0]   state,
   output logic [1:0]   nxt_state,
   output logic         wrap
);

   localparam logic [W-1:0] ONE       = W'(1);
   localparam logic [W-1:0] LAST      = W'(TOTAL - 1);
   localparam logic [W-1:0] ACT_LAST  = W'(ACTIVE - 1);
   localparam logic [W-1:0] FP_LAST   = W'(FP - 1);
   localparam logic [W-1:0] SYNC_LAST = W'(SYNC - 1);
   localparam logic [W-1:0] BP_LAST   = W'(BP - 1);

   logic [W-1:0] r_pos;
   logic [W-1:0] r_len;
   vga_axis_e    r_state;

   logic [W-1:0] w_len_last;
   logic [W-1:0] w_pos_adv;
   logic [W-1:0] w_len_adv;
   logic         w_len_done;
   vga_axis_e    w_state_succ;
   vga_axis_e    w_state_adv;

   always_comb begin
      w_len_last   = ACT_LAST;
      w_state_succ = AX_FRONT;
      unique case (r_state)
         AX_ACTIVE: begin
            w_len_last   = ACT_LAST;
            w_state_succ = AX_FRONT;
         end
         AX_FRONT: begin
            w_len_last   = FP_LAST;
            w_state_succ = AX_SYNC;
         end
         AX_SYNC: begin
            w_len_last   = SYNC_LAST;
            w_state_succ = AX_BACK;
         end
         AX_BACK: begin
            w_len_last   = BP_LAST;
            w_state_succ = AX_ACTIVE;
         end
      endcase
   end

   // Values the axis takes on its next advance, independent of adv, so the
   // parent can register flags that line up with the position registers.
   assign wrap        = (r_pos == LAST);
   assign w_len_done  = (r_len == w_len_last);
   assign w_pos_adv   = wrap ? '0 : r_pos + ONE;
   assign w_len_adv   = w_len_done ? '0 : r_len + ONE;
   assign w_state_adv = w_len_done ? w_state_succ : r_state;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_pos   <= '0;
         r_len   <= '0;
         r_state <= AX_ACTIVE;
      end else if (adv) begin
         r_pos   <= w_pos_adv;
         r_len   <= w_len_adv;
         r_state <= w_state_adv;
      end
   end

   assign pos       = r_pos;
   assign state     = r_state;
   assign nxt_state = w_state_adv;

endmodule

// File: rtl/vga_scan_gen.sv
// VGA raster timing generator: col/row scan with registered, mutually aligned
// sync, blank and frame-start outputs. Define VGA_PIXEL_DIV_EN for a /2 pixel clock.
module vga_scan_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
   parameter int unsigned H_FP     = VGA_H_FP,
   parameter int unsigned H_SYNC   = VGA_H_SYNC,
   parameter int unsigned H_BP     = VGA_H_BP,
   parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
   parameter int unsigned V_FP     = VGA_V_FP,
   parameter int unsigned V_SYNC   = VGA_V_SYNC,
   parameter int unsigned V_BP     = VGA_V_BP,
   parameter logic        SYNC_POL = 1'b0
) (
   input  logic        CLK,
   input  logic        RST,
   output logic [31:0] col,
   output logic [31:0] row,
   output logic        hsync,
   output logic        vsync,
   output logic        vnotactive,
   output logic        blank,
   output logic        frame_start,
   output logic        pix_en
);

   localparam int unsigned HW = vga_cnt_w(H_ACTIVE + H_FP + H_SYNC + H_BP);
   localparam int unsigned VW = vga_cnt_w(V_ACTIVE + V_FP + V_SYNC + V_BP);

   logic          w_pix_en;
   logic          w_v_adv;
   logic [HW-1:0] w_h_pos;
   logic [VW-1:0] w_v_pos;
   logic [1:0]    w_h_state;
   logic [1:0]    w_v_state;
   logic [1:0]    w_h_nxt;
   logic [1:0]    w_v_nxt;
   logic [1:0]    w_h_sel;
   logic [1:0]    w_v_sel;
   logic          w_h_wrap;
   logic          w_v_wrap;

   logic r_hsync;
   logic r_vsync;
   logic r_blank;
   logic r_vnotactive;
   logic r_frame_start;

`ifdef VGA_PIXEL_DIV_EN
   logic r_pix_en;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_pix_en <= 1'b0;
      end else begin
         r_pix_en <= ~r_pix_en;
      end
   end

   assign w_pix_en = r_pix_en;
`else
   assign w_pix_en = 1'b1;
`endif

   assign w_v_adv = w_h_wrap & w_pix_en;

   vga_axis_counter #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP)
   ) u_h_axis (
      .CLK       (CLK),
      .RST       (RST),
      .adv       (w_pix_en),
      .pos       (w_h_pos),
      .state     (w_h_state),
      .nxt_state (w_h_nxt),
      .wrap      (w_h_wrap)
   );

   vga_axis_counter #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP)
   ) u_v_axis (
      .CLK       (CLK),
      .RST       (RST),
      .adv       (w_v_adv),
      .pos       (w_v_pos),
      .state     (w_v_state),
      .nxt_state (w_v_nxt),
      .wrap      (w_v_wrap)
   );

   // Flags are registered from the state each axis holds after this edge,
   // keeping them in the same pixel period as col/row.
   assign w_h_sel = w_pix_en ? w_h_nxt : w_h_state;
   assign w_v_sel = w_v_adv ? w_v_nxt : w_v_state;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_hsync       <= ~SYNC_POL;
         r_vsync       <= ~SYNC_POL;
         r_blank       <= 1'b0;
         r_vnotactive  <= 1'b0;
         r_frame_start <= 1'b1;
      end else begin
         r_hsync       <= (w_h_sel == AX_SYNC) ? SYNC_POL : ~SYNC_POL;
         r_vsync       <= (w_v_sel == AX_SYNC) ? SYNC_POL : ~SYNC_POL;
         r_blank       <= (w_h_sel != AX_ACTIVE) || (w_v_sel != AX_ACTIVE);
         r_vnotactive  <= (w_v_sel != AX_ACTIVE);
         r_frame_start <= w_pix_en ? (w_h_wrap & w_v_wrap) : r_frame_start;
      end
   end

   assign col         = 32'(w_h_pos);
   assign row         = 32'(w_v_pos);
   assign hsync       = r_hsync;
   assign vsync       = r_vsync;
   assign blank       = r_blank;
   assign vnotactive  = r_vnotactive;
   assign frame_start = r_frame_start;
   assign pix_en      = w_pix_en;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Directed bench for vga_scan_gen: default 640x480 line timing, reset, pixel
// strobe, and full frames of a small-parameter build with both sync polarities.
module tb_vga_scan_gen;

`ifdef VGA_PIXEL_DIV_EN
   localparam int PDIV = 2;
`else
   localparam int PDIV = 1;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   logic [31:0] d_col, d_row, s_col, s_row, p_col, p_row;
   logic d_hs, d_vs, d_vna, d_blank, d_fs, d_pe;
   logic s_hs, s_vs, s_vna, s_blank, s_fs, s_pe;
   logic p_hs, p_vs, p_vna, p_blank, p_fs, p_pe;

   vga_scan_gen u_dut_def (
      .CLK (clk), .RST (rst), .col (d_col), .row (d_row), .hsync (d_hs), .vsync (d_vs),
      .vnotactive (d_vna), .blank (d_blank), .frame_start (d_fs), .pix_en (d_pe)
   );

   vga_scan_gen #(
      .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
      .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1), .SYNC_POL (1'b0)
   ) u_dut_small (
      .CLK (clk), .RST (rst), .col (s_col), .row (s_row), .hsync (s_hs), .vsync (s_vs),
      .vnotactive (s_vna), .blank (s_blank), .frame_start (s_fs), .pix_en (s_pe)
   );

   vga_scan_gen #(
      .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
      .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1), .SYNC_POL (1'b1)
   ) u_dut_pol (
      .CLK (clk), .RST (rst), .col (p_col), .row (p_row), .hsync (p_hs), .vsync (p_vs),
      .vnotactive (p_vna), .blank (p_blank), .frame_start (p_fs), .pix_en (p_pe)
   );

   task automatic step_pix;
      repeat (PDIV) @(negedge clk);
   endtask

   task automatic do_reset;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset;
      logic e_pe;
      e_pe = (PDIV == 2) ? 1'b0 : 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (37 * PDIV) @(negedge clk);
      rst = 1'b1;
      #1;
      total += 9;
      if (d_col !== 32'd0) begin bad++; $display("FAIL reset_col got=%0d want=0", d_col); end
      if (d_row !== 32'd0) begin bad++; $display("FAIL reset_row got=%0d want=0", d_row); end
      if (d_hs !== 1'b1) begin bad++; $display("FAIL reset_hsync got=%b want=1", d_hs); end
      if (d_vs !== 1'b1) begin bad++; $display("FAIL reset_vsync got=%b want=1", d_vs); end
      if (d_blank !== 1'b0) begin bad++; $display("FAIL reset_blank got=%b want=0", d_blank); end
      if (d_vna !== 1'b0) begin bad++; $display("FAIL reset_vna got=%b want=0", d_vna); end
      if (d_fs !== 1'b1) begin bad++; $display("FAIL reset_fs got=%b want=1", d_fs); end
      if (d_pe !== e_pe) begin bad++; $display("FAIL reset_pix_en got=%b want=%b", d_pe, e_pe); end
      if (p_hs !== 1'b0 || p_vs !== 1'b0) begin
         bad++;
         $display("FAIL reset_pol1_sync got=%b%b want=00", p_hs, p_vs);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         step_pix();
         total++;
         if (d_col !== 32'(i)) begin
            bad++;
            $display("FAIL release_col step=%0d got=%0d want=%0d", i, d_col, i);
         end
      end
   endtask

   task automatic test_pix_en;
      int  e_col;
      logic e_pe;
      do_reset();
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         e_col = (PDIV == 2) ? i / 2 : i;
         e_pe  = (PDIV == 2) ? 1'(i % 2) : 1'b1;
         total += 2;
         if (d_col !== 32'(e_col)) begin
            bad++;
            $display("FAIL pix_col clk=%0d got=%0d want=%0d", i, d_col, e_col);
         end
         if (d_pe !== e_pe) begin
            bad++;
            $display("FAIL pix_en clk=%0d got=%b want=%b", i, d_pe, e_pe);
         end
      end
   endtask

   task automatic test_hline;
      int   c, r;
      logic e_hs, e_blank;
      do_reset();
      for (int k = 0; k <= 801; k++) begin
         c = k % 800;
         r = k / 800;
         e_hs    = (c >= 656 && c < 752) ? 1'b0 : 1'b1;
         e_blank = (c >= 640);
         total += 6;
         if (d_col !== 32'(c)) begin bad++; $display("FAIL hline_col k=%0d got=%0d want=%0d", k, d_col, c); end
         if (d_row !== 32'(r)) begin bad++; $display("FAIL hline_row k=%0d got=%0d want=%0d", k, d_row, r); end
         if (d_hs !== e_hs) begin bad++; $display("FAIL hline_hsync col=%0d got=%b want=%b", c, d_hs, e_hs); end
         if (d_blank !== e_blank) begin
            bad++;
            $display("FAIL hline_blank col=%0d got=%b want=%b", c, d_blank, e_blank);
         end
         if (d_vs !== 1'b1) begin bad++; $display("FAIL hline_vsync col=%0d got=%b want=1", c, d_vs); end
         if (d_fs !== (k == 0)) begin
            bad++;
            $display("FAIL hline_fs col=%0d got=%b want=%b", c, d_fs, (k == 0));
         end
         step_pix();
      end
   endtask

   task automatic test_small_frames;
      int   c, r, n_fs;
      logic e_hs, e_vs, e_vna, e_blank, e_fs;
      n_fs = 0;
      do_reset();
      for (int k = 0; k <= 96; k++) begin
         c = k % 8;
         r = (k / 8) % 6;
         e_hs    = (c >= 5 && c < 7);
         e_vs    = (r == 4);
         e_vna   = (r >= 3);
         e_blank = (c >= 4) || (r >= 3);
         e_fs    = (c == 0) && (r == 0);
         if (s_fs === 1'b1) n_fs++;
         total += 9;
         if (s_col !== 32'(c) || s_row !== 32'(r)) begin
            bad++;
            $display("FAIL small_pos k=%0d got=(%0d,%0d) want=(%0d,%0d)", k, s_row, s_col, r, c);
         end
         if (s_hs !== ~e_hs) begin bad++; $display("FAIL small_hsync k=%0d got=%b want=%b", k, s_hs, ~e_hs); end
         if (s_vs !== ~e_vs) begin bad++; $display("FAIL small_vsync k=%0d got=%b want=%b", k, s_vs, ~e_vs); end
         if (s_vna !== e_vna) begin bad++; $display("FAIL small_vna k=%0d got=%b want=%b", k, s_vna, e_vna); end
         if (s_blank !== e_blank) begin
            bad++;
            $display("FAIL small_blank k=%0d got=%b want=%b", k, s_blank, e_blank);
         end
         if (s_fs !== e_fs) begin bad++; $display("FAIL small_fs k=%0d got=%b want=%b", k, s_fs, e_fs); end
         if (p_hs !== e_hs) begin bad++; $display("FAIL pol1_hsync k=%0d got=%b want=%b", k, p_hs, e_hs); end
         if (p_vs !== e_vs) begin bad++; $display("FAIL pol1_vsync k=%0d got=%b want=%b", k, p_vs, e_vs); end
         if (p_col !== s_col || p_blank !== e_blank) begin
            bad++;
            $display("FAIL pol1_pos k=%0d col=%0d blank=%b want col=%0d blank=%b",
                     k, p_col, p_blank, c, e_blank);
         end
         step_pix();
      end
      // Pixels 0, 48 and 96 are frame starts: 48-pixel frame period.
      total++;
      if (n_fs != 3) begin bad++; $display("FAIL small_fs_count got=%0d want=3", n_fs); end
   endtask

   initial begin
      test_reset();
      test_pix_en();
      test_hline();
      test_small_frames();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
